axi_lite_client_arbiter: RTL and testbench

- Shares one AXI4-lite slave port (the LED/seven-segment/IRQ peripheral register slave) between two on-chip clients.
- Each client issues single read or write requests over a simple req/done interface.
- The block arbitrates round-robin, sequences the full AXI4-lite handshake (AW/W/B or AR/R) with one transaction outstanding, and returns read data and response to the granted client.

---
 rtl/axi_lite_client_arbiter_if.sv | 38 +++
 rtl/axi_lite_client_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_client_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_client_arbiter_if.sv
// AXI4-lite master-side bus bundle used by axi_lite_client_arbiter.
// The master modport is the arbiter; the slave modport is the register peripheral.
interface axi_lite_client_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]     M_AWADDR;
  logic                      M_AWVALID;
  logic                      M_AWREADY;
  logic [DATA_WIDTH-1:0]     M_WDATA;
  logic [DATA_WIDTH/8-1:0]   M_WSTRB;
  logic                      M_WVALID;
  logic                      M_WREADY;
  logic                      M_BVALID;
  logic [1:0]                M_BRESP;
  logic                      M_BREADY;
  logic [ADDR_WIDTH-1:0]     M_ARADDR;
  logic                      M_ARVALID;
  logic                      M_ARREADY;
  logic                      M_RVALID;
  logic [DATA_WIDTH-1:0]     M_RDATA;
  logic [1:0]                M_RRESP;
  logic                      M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY,
    input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
           M_ARREADY, M_RVALID, M_RDATA, M_RRESP
  );

  modport slave (
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY,
    output M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
           M_ARREADY, M_RVALID, M_RDATA, M_RRESP
  );
endinterface

// File: rtl/axi_lite_client_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite slave between two req/done clients,
// one transaction outstanding, all outputs registered.
module axi_lite_client_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [1:0]                    c_req,
  input  logic [1:0]                    c_we,
  input  logic [2*ADDR_WIDTH-1:0]       c_addr,
  input  logic [2*DATA_WIDTH-1:0]       c_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]   c_wstrb,
  output logic [1:0]                    c_done,
  output logic [DATA_WIDTH-1:0]         c_rdata,
  output logic [1:0]                    c_resp,
  output logic [1:0]                    gnt,
  axi_lite_client_arbiter_if.master     m_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                  state_r,      state_s;
  logic                    last_grant_r, last_grant_s;
  logic [1:0]              gnt_r,        gnt_s;
  logic [1:0]              c_done_r,     c_done_s;
  logic [DATA_WIDTH-1:0]   c_rdata_r,    c_rdata_s;
  logic [1:0]              c_resp_r,     c_resp_s;
  logic [ADDR_WIDTH-1:0]   awaddr_r,     awaddr_s;
  logic [DATA_WIDTH-1:0]   wdata_r,      wdata_s;
  logic [STRB_WIDTH-1:0]   wstrb_r,      wstrb_s;
  logic [ADDR_WIDTH-1:0]   araddr_r,     araddr_s;
  logic                    awvalid_r,    awvalid_s;
  logic                    wvalid_r,     wvalid_s;
  logic                    bready_r,     bready_s;
  logic                    arvalid_r,    arvalid_s;
  logic                    rready_r,     rready_s;

  logic                    pick_s;
  logic                    aw_fin_s;
  logic                    w_fin_s;

  // Round-robin choice: a lone request wins, a tie goes to the client not served last
  always_comb begin
    pick_s = 1'b0;
    case (c_req)
      2'b01:   pick_s = 1'b0;
      2'b10:   pick_s = 1'b1;
      2'b11:   pick_s = ~last_grant_r;
      default: pick_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    gnt_s        = gnt_r;
    c_done_s     = 2'b00;
    c_rdata_s    = c_rdata_r;
    c_resp_s     = c_resp_r;
    awaddr_s     = awaddr_r;
    wdata_s      = wdata_r;
    wstrb_s      = wstrb_r;
    araddr_s     = araddr_r;
    awvalid_s    = awvalid_r;
    wvalid_s     = wvalid_r;
    bready_s     = bready_r;
    arvalid_s    = arvalid_r;
    rready_s     = rready_r;
    // A channel counts as finished once its valid is gone or handshakes this cycle
    aw_fin_s     = ~awvalid_r | m_axi.M_AWREADY;
    w_fin_s      = ~wvalid_r  | m_axi.M_WREADY;

    case (state_r)
      ST_IDLE: begin
        if (c_req != 2'b00) begin
          last_grant_s = pick_s;
          gnt_s        = pick_s ? 2'b10 : 2'b01;
          if (c_we[pick_s]) begin
            awaddr_s  = pick_s ? c_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]   : c_addr[ADDR_WIDTH-1:0];
            wdata_s   = pick_s ? c_wdata[2*DATA_WIDTH-1:DATA_WIDTH]  : c_wdata[DATA_WIDTH-1:0];
            wstrb_s   = pick_s ? c_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]  : c_wstrb[STRB_WIDTH-1:0];
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            state_s   = ST_WR_REQ;
          end else begin
            araddr_s  = pick_s ? c_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]   : c_addr[ADDR_WIDTH-1:0];
            arvalid_s = 1'b1;
            state_s   = ST_RD_ADDR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WR_REQ: begin
        if (awvalid_r && m_axi.M_AWREADY) begin
          awvalid_s = 1'b0;
        end else begin
          awvalid_s = awvalid_r;
        end
        if (wvalid_r && m_axi.M_WREADY) begin
          wvalid_s = 1'b0;
        end else begin
          wvalid_s = wvalid_r;
        end
        if (aw_fin_s && w_fin_s) begin
          bready_s = 1'b1;
          state_s  = ST_WR_RESP;
        end else begin
          state_s  = ST_WR_REQ;
        end
      end

      ST_WR_RESP: begin
        if (m_axi.M_BVALID) begin
          c_resp_s  = m_axi.M_BRESP;
          c_rdata_s = {DATA_WIDTH{1'b0}};
          bready_s  = 1'b0;
          c_done_s  = gnt_r;
          state_s   = ST_DONE;
        end else begin
          state_s   = ST_WR_RESP;
        end
      end

      ST_RD_ADDR: begin
        if (m_axi.M_ARREADY) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = ST_RD_DATA;
        end else begin
          state_s   = ST_RD_ADDR;
        end
      end

      ST_RD_DATA: begin
        if (m_axi.M_RVALID) begin
          c_rdata_s = m_axi.M_RDATA;
          c_resp_s  = m_axi.M_RRESP;
          rready_s  = 1'b0;
          c_done_s  = gnt_r;
          state_s   = ST_DONE;
        end else begin
          state_s   = ST_RD_DATA;
        end
      end

      ST_DONE: begin
        gnt_s   = 2'b00;
        state_s = ST_IDLE;
      end

      default: begin
        gnt_s     = 2'b00;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        bready_s  = 1'b0;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight without a done pulse
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      gnt_r        <= 2'b00;
      c_done_r     <= 2'b00;
      c_rdata_r    <= {DATA_WIDTH{1'b0}};
      c_resp_r     <= 2'b00;
      awaddr_r     <= {ADDR_WIDTH{1'b0}};
      wdata_r      <= {DATA_WIDTH{1'b0}};
      wstrb_r      <= {STRB_WIDTH{1'b0}};
      araddr_r     <= {ADDR_WIDTH{1'b0}};
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      gnt_r        <= gnt_s;
      c_done_r     <= c_done_s;
      c_rdata_r    <= c_rdata_s;
      c_resp_r     <= c_resp_s;
      awaddr_r     <= awaddr_s;
      wdata_r      <= wdata_s;
      wstrb_r      <= wstrb_s;
      araddr_r     <= araddr_s;
      awvalid_r    <= awvalid_s;
      wvalid_r     <= wvalid_s;
      bready_r     <= bready_s;
      arvalid_r    <= arvalid_s;
      rready_r     <= rready_s;
    end
  end

  assign gnt              = gnt_r;
  assign c_done           = c_done_r;
  assign c_rdata          = c_rdata_r;
  assign c_resp           = c_resp_r;
  assign m_axi.M_AWADDR   = awaddr_r;
  assign m_axi.M_AWVALID  = awvalid_r;
  assign m_axi.M_WDATA    = wdata_r;
  assign m_axi.M_WSTRB    = wstrb_r;
  assign m_axi.M_WVALID   = wvalid_r;
  assign m_axi.M_BREADY   = bready_r;
  assign m_axi.M_ARADDR   = araddr_r;
  assign m_axi.M_ARVALID  = arvalid_r;
  assign m_axi.M_RREADY   = rready_r;

endmodule

// File: tb/tb_axi_lite_client_arbiter.sv
// Scoreboard bench for axi_lite_client_arbiter: directed client transactions against
// a delay-configurable AXI4-lite slave model; a monitor checks every c_done.
module tb_axi_lite_client_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [1:0]      c_req;
  logic [1:0]      c_we;
  logic [2*AW-1:0] c_addr;
  logic [2*DW-1:0] c_wdata;
  logic [7:0]      c_wstrb;
  logic [1:0]      c_done;
  logic [DW-1:0]   c_rdata;
  logic [1:0]      c_resp;
  logic [1:0]      gnt;

  axi_lite_client_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_client_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_wstrb (c_wstrb),
    .c_done  (c_done),
    .c_rdata (c_rdata),
    .c_resp  (c_resp),
    .gnt     (gnt),
    .m_axi   (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  done;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;
  exp_t exp_q[$];

  // slave model configuration and captured request fields
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_client(input int c, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    c_we[c]            = we;
    c_addr[c*AW +: AW] = a;
    c_wdata[c*DW +: DW] = d;
    c_wstrb[c*4 +: 4]  = s;
  endtask

  task automatic push(input logic [1:0] done, input logic [1:0] resp, input logic [31:0] rdata,
                      input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.done = done; e.resp = resp; e.rdata = rdata; e.we = we;
    e.addr = a; e.wdata = d; e.strb = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input logic [1:0] mask, output int gcyc, output int awc,
                           output int wc, output logic [1:0] seen);
    gcyc = 0; awc = 0; wc = 0; seen = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (gnt != 2'b00) gcyc++;
      if (bus.M_AWVALID) awc++;
      if (bus.M_WVALID) wc++;
      if ((c_done & mask) != 2'b00) begin
        seen = c_done;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL timeout: no c_done for mask %b", mask);
  endtask

  // AXI4-lite slave: samples handshakes at the edge, updates its outputs 1 time unit later
  initial begin
    int aw_c, w_c, ar_c, b_c, r_c;
    bit aw_ok, w_ok, b_pend, r_pend;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    aw_ok = 0; w_ok = 0; b_pend = 0; r_pend = 0;
    bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0; bus.M_BRESP = 2'b00;
    bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_RDATA = 32'h0; bus.M_RRESP = 2'b00;
    forever begin
      @(posedge ACLK);
      if (!ARESETn) begin
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        aw_ok = 0; w_ok = 0; b_pend = 0; r_pend = 0;
      end else begin
        if (bus.M_BVALID && bus.M_BREADY) b_pend = 0;
        else if (b_pend) b_c++;
        if (bus.M_AWVALID && bus.M_AWREADY) begin
          cap_awaddr = bus.M_AWADDR; aw_ok = 1; aw_c = 0;
        end else if (bus.M_AWVALID) aw_c++;
        if (bus.M_WVALID && bus.M_WREADY) begin
          cap_wdata = bus.M_WDATA; cap_wstrb = bus.M_WSTRB; w_ok = 1; w_c = 0;
        end else if (bus.M_WVALID) w_c++;
        if (aw_ok && w_ok) begin
          aw_ok = 0; w_ok = 0; b_pend = 1; b_c = 0;
        end
        if (bus.M_RVALID && bus.M_RREADY) r_pend = 0;
        else if (r_pend) r_c++;
        if (bus.M_ARVALID && bus.M_ARREADY) begin
          cap_araddr = bus.M_ARADDR; ar_c = 0; r_pend = 1; r_c = 0;
        end else if (bus.M_ARVALID) ar_c++;
      end
      #1;
      bus.M_AWREADY = bus.M_AWVALID && (aw_c >= aw_dly);
      bus.M_WREADY  = bus.M_WVALID  && (w_c  >= w_dly);
      bus.M_ARREADY = bus.M_ARVALID && (ar_c >= ar_dly);
      bus.M_BVALID  = b_pend && (b_c >= b_dly);
      bus.M_BRESP   = bus.M_BVALID ? bresp_cfg : 2'b00;
      bus.M_RVALID  = r_pend && (r_c >= r_dly);
      bus.M_RDATA   = bus.M_RVALID ? rdata_cfg : 32'h0;
      bus.M_RRESP   = bus.M_RVALID ? rresp_cfg : 2'b00;
    end
  end

  // Monitor: pops the scoreboard on every c_done and checks per-cycle bus invariants
  initial begin
    exp_t e;
    logic [1:0] prev_done;
    prev_done = 2'b00;
    forever begin
      @(negedge ACLK);
      if (ARESETn === 1'b1) begin
        if (!$onehot0(gnt)) check("gnt_onehot", {62'h0, gnt}, 64'h1);
        if ((bus.M_AWVALID || bus.M_WVALID || bus.M_BREADY) && (bus.M_ARVALID || bus.M_RREADY))
          check("bus_overlap", 64'h1, 64'h0);
        if (bus.M_BREADY && (bus.M_AWVALID || bus.M_WVALID))
          check("bready_early", 64'h1, 64'h0);
        if (prev_done != 2'b00) check("done_pulse", {62'h0, c_done}, 64'h0);
        if (c_done != 2'b00) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_done: c_done=%b with no transaction pending", c_done);
          end else begin
            e = exp_q.pop_front();
            check("done_client", {62'h0, c_done}, {62'h0, e.done});
            check("c_resp",      {62'h0, c_resp}, {62'h0, e.resp});
            check("c_rdata",     {32'h0, c_rdata}, {32'h0, e.rdata});
            if (e.we) begin
              check("m_awaddr", {32'h0, cap_awaddr}, {32'h0, e.addr});
              check("m_wdata",  {32'h0, cap_wdata},  {32'h0, e.wdata});
              check("m_wstrb",  {60'h0, cap_wstrb},  {60'h0, e.strb});
            end else begin
              check("m_araddr", {32'h0, cap_araddr}, {32'h0, e.addr});
            end
          end
        end
        prev_done = c_done;
      end else begin
        prev_done = 2'b00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    logic [1:0] seen;
    logic [1:0] rr_exp [4];
    logic       quiet;
    int         g, a, w;
    ARESETn = 1'b0;
    c_req = 2'b00; c_we = 2'b00; c_addr = '0; c_wdata = '0; c_wstrb = 8'h00;
    repeat (3) @(negedge ACLK);
    check("reset_ctrl", {54'h0, gnt, c_done, c_resp, bus.M_AWVALID, bus.M_WVALID},
          64'h0);
    check("reset_regs", {bus.M_AWADDR, bus.M_ARADDR}, 64'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // zero-wait read by client 0
    rdata_cfg = 32'h12345678; rresp_cfg = 2'b00;
    set_client(0, 1'b0, 32'h20, 32'h0, 4'h0);
    push(2'b01, 2'b00, 32'h12345678, 1'b0, 32'h20, 32'h0, 4'h0);
    c_req[0] = 1'b1;
    wait_done(2'b01, g, a, w, seen);
    c_req[0] = 1'b0;
    check("latency_rd", g, 3);

    // client 1 read, RVALID delayed, SLVERR passed through
    r_dly = 4; rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b10;
    set_client(1, 1'b0, 32'h10, 32'h0, 4'h0);
    push(2'b10, 2'b10, 32'hDEADBEEF, 1'b0, 32'h10, 32'h0, 4'h0);
    c_req[1] = 1'b1;
    wait_done(2'b10, g, a, w, seen);
    check("rready_after_capture", {63'h0, bus.M_RREADY}, 64'h0);
    c_req[1] = 1'b0;
    r_dly = 0;

    // zero-wait write by client 0
    bresp_cfg = 2'b00;
    set_client(0, 1'b1, 32'h04, 32'hA5, 4'hF);
    push(2'b01, 2'b00, 32'h0, 1'b1, 32'h04, 32'hA5, 4'hF);
    c_req[0] = 1'b1;
    wait_done(2'b01, g, a, w, seen);
    c_req[0] = 1'b0;
    check("latency_wr", g, 3);

    // AWREADY delayed two cycles, WREADY immediate
    aw_dly = 2; bresp_cfg = 2'b11;
    set_client(1, 1'b1, 32'h0C, 32'h5A5A5A5A, 4'h3);
    push(2'b10, 2'b11, 32'h0, 1'b1, 32'h0C, 32'h5A5A5A5A, 4'h3);
    c_req[1] = 1'b1;
    wait_done(2'b10, g, a, w, seen);
    c_req[1] = 1'b0;
    check("awvalid_cycles", a, 3);
    check("wvalid_cycles", w, 1);
    aw_dly = 0; bresp_cfg = 2'b00;

    // both clients request continuously: alternate grants
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    set_client(0, 1'b1, 32'h00, 32'h11, 4'hF);
    set_client(1, 1'b1, 32'h08, 32'h22, 4'hF);
    push(2'b01, 2'b00, 32'h0, 1'b1, 32'h00, 32'h11, 4'hF);
    push(2'b10, 2'b00, 32'h0, 1'b1, 32'h08, 32'h22, 4'hF);
    push(2'b01, 2'b00, 32'h0, 1'b1, 32'h00, 32'h11, 4'hF);
    push(2'b10, 2'b00, 32'h0, 1'b1, 32'h08, 32'h22, 4'hF);
    c_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(2'b11, g, a, w, seen);
      check("rr_order", {62'h0, seen}, {62'h0, rr_exp[k]});
    end
    c_req = 2'b00;

    // client 0 drops req in DONE: block must stay quiet
    set_client(0, 1'b1, 32'h14, 32'h77, 4'hF);
    push(2'b01, 2'b00, 32'h0, 1'b1, 32'h14, 32'h77, 4'hF);
    c_req[0] = 1'b1;
    wait_done(2'b01, g, a, w, seen);
    c_req[0] = 1'b0;
    quiet = 1'b0;
    repeat (6) begin
      @(negedge ACLK);
      quiet = quiet | (gnt != 2'b00) | (c_done != 2'b00) | bus.M_AWVALID | bus.M_WVALID
                    | bus.M_ARVALID | bus.M_BREADY | bus.M_RREADY;
    end
    check("idle_quiet", {63'h0, quiet}, 64'h0);

    // reset while waiting for BVALID; afterwards client 0 wins the tie
    b_dly = 10;
    set_client(0, 1'b1, 32'h18, 32'h33, 4'hF);
    c_req[0] = 1'b1;
    seen = 2'b00;
    for (int i = 0; i < 50 && seen == 2'b00; i++) begin
      @(negedge ACLK);
      if (bus.M_BREADY) seen = 2'b01;
    end
    check("bready_reached", {62'h0, seen}, 64'h1);
    set_client(1, 1'b1, 32'h1C, 32'h44, 4'hF);
    c_req[1] = 1'b1;
    ARESETn = 1'b0;
    #1;
    check("rst_ctrl", {56'h0, gnt, c_done, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY,
                       bus.M_ARVALID}, 64'h0);
    check("rst_rready", {63'h0, bus.M_RREADY}, 64'h0);
    check("rst_addr", {bus.M_AWADDR, bus.M_ARADDR}, 64'h0);
    check("rst_data", {24'h0, bus.M_WDATA, bus.M_WSTRB, 4'h0}, 64'h0);
    check("rst_client", {30'h0, c_rdata, c_resp}, 64'h0);
    b_dly = 0;
    repeat (2) @(negedge ACLK);
    push(2'b01, 2'b00, 32'h0, 1'b1, 32'h18, 32'h33, 4'hF);
    push(2'b10, 2'b00, 32'h0, 1'b1, 32'h1C, 32'h44, 4'hF);
    ARESETn = 1'b1;
    wait_done(2'b11, g, a, w, seen);
    check("post_reset_first", {62'h0, seen}, 64'h1);
    wait_done(2'b11, g, a, w, seen);
    check("post_reset_second", {62'h0, seen}, 64'h2);
    c_req = 2'b00;
    repeat (4) @(negedge ACLK);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
